// File: rtl/lsu_load.sv
// Load-side memory path: takes one load from execute, reads the containing word over a
// valid/ready bus, extracts and extends the addressed lane, and hands it to writeback.
module lsu_load #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  ld_funct3,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    output logic        mem_rsp_ready,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic        wb_fault,
    output logic [1:0]  state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // once valid is raised the payload is held stable until that edge.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                state;
    state_t                state_next;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [31:0]           addr_q;
    logic [2:0]            funct3_q;
    logic                  ld_bad;
    logic                  timeout_hit;
    logic [31:0]           rsp_ext;

    // Loads that can never be issued: unknown funct3 or a lane crossing its natural alignment.
    always_comb begin
        ld_bad = 1'b0;
        case (ld_funct3)
            3'b000, 3'b100: ld_bad = 1'b0;
            3'b001, 3'b101: ld_bad = ld_addr[0];
            3'b010:         ld_bad = (ld_addr[1:0] != 2'b00);
            default:        ld_bad = 1'b1;
        endcase
    end

    always_comb begin
        logic [7:0]  lane_byte;
        logic [15:0] lane_half;
        lane_byte = mem_rsp_data[{addr_q[1:0], 3'b000} +: 8];
        lane_half = addr_q[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
        case (funct3_q)
            3'b000:  rsp_ext = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  rsp_ext = {24'd0, lane_byte};
            3'b001:  rsp_ext = {{16{lane_half[15]}}, lane_half};
            3'b101:  rsp_ext = {16'd0, lane_half};
            default: rsp_ext = mem_rsp_data;
        endcase
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (ld_valid) state_next = ld_bad ? S_DONE : S_REQ;
            S_REQ:  if (mem_req_ready) state_next = S_WAIT;
            S_WAIT: if (mem_rsp_valid || timeout_hit) state_next = S_DONE;
            S_DONE: if (wb_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ld_ready      = (state == S_IDLE);
        mem_req_valid = (state == S_REQ);
        wb_valid      = (state == S_DONE);
        mem_req_addr  = {addr_q[31:2], 2'b00};
        mem_rsp_ready = 1'b1;
        state_dbg     = state;
    end

    // Datapath registers; a response seen outside WAIT falls through every branch and is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            addr_q   <= '0;
            funct3_q <= '0;
            wb_data  <= '0;
            wb_fault <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ld_valid) begin
                        addr_q   <= ld_addr;
                        funct3_q <= ld_funct3;
                        wb_data  <= '0;
                        wb_fault <= ld_bad;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) cnt <= '0;
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        wb_data  <= mem_rsp_err ? 32'd0 : rsp_ext;
                        wb_fault <= mem_rsp_err;
                    end else if (timeout_hit) begin
                        wb_data  <= '0;
                        wb_fault <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_load.sv
// Bench for lsu_load: driver for the load and memory sides, reference model feeding an
// expected queue, and a writeback monitor that randomises wb_ready and checks each result.
module tb_lsu_load;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [31:0] ld_addr = '0;
    logic [2:0]  ld_funct3 = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic        mem_rsp_ready;
    logic [31:0] mem_rsp_data = '0;
    logic        mem_rsp_err = 1'b0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [31:0] wb_data;
    logic        wb_fault;
    logic [1:0]  state_dbg;

    int n_cmp = 0;
    int n_bad = 0;
    int hold_req = 0;
    logic [32:0] exp_q[$];

    lsu_load #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_fault(wb_fault),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: a load faults unless funct3 names a real size and the address is a multiple of it.
    function automatic logic model_fault(input logic [31:0] addr, input logic [2:0] f3);
        int size;
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        size = 1 << f3[1:0];
        return (addr % size) != 0;
    endfunction

    function automatic logic [31:0] model_data(input logic [31:0] addr, input logic [2:0] f3,
                                               input logic [31:0] word);
        int size;
        longint unsigned v;
        size = 1 << f3[1:0];
        v = (longint'(word) >> (8 * (addr % 4))) & ((64'd1 << (8 * size)) - 1);
        if (!f3[2] && size < 4 && v >= (64'd1 << (8 * size - 1)))
            v = v + (64'd1 << 32) - (64'd1 << (8 * size));
        return v[31:0];
    endfunction

    task automatic wait_ld_ready(output logic ok);
        int n = 0;
        @(negedge clk);
        while (!ld_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = ld_ready;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ld_ready_timeout: got 0, expected 1");
        end
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] word,
                           input logic err, input int req_dly, input int rsp_dly);
        logic ok;
        logic flt;
        int n;
        wait_ld_ready(ok);
        if (!ok) return;
        ld_valid = 1'b1;
        ld_addr = addr;
        ld_funct3 = f3;
        flt = model_fault(addr, f3);
        if (flt)
            exp_q.push_back({1'b1, 32'd0});
        else if (rsp_dly >= TMO)
            exp_q.push_back({1'b1, 32'd0});
        else if (err)
            exp_q.push_back({1'b1, 32'd0});
        else
            exp_q.push_back({1'b0, model_data(addr, f3, word)});
        @(posedge clk);
        #1 ld_valid = 1'b0;
        ld_addr = $urandom;
        ld_funct3 = 3'($urandom);
        @(negedge clk);
        if (flt) begin
            check("bad_no_req", 64'(mem_req_valid), 64'd0);
            check("bad_wb_valid_1cyc", 64'(wb_valid), 64'd1);
            return;
        end
        n = 0;
        while (!mem_req_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_valid", 64'(mem_req_valid), 64'd1);
        check("req_addr", 64'(mem_req_addr), 64'(addr & 32'hFFFF_FFFC));
        repeat (req_dly) @(negedge clk);
        check("req_addr_held", 64'(mem_req_addr), 64'(addr & 32'hFFFF_FFFC));
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1 mem_req_ready = 1'b0;
        @(negedge clk);
        repeat (rsp_dly) @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rsp_data = word;
        mem_rsp_err = err;
        @(posedge clk);
        #1 mem_rsp_valid = 1'b0;
        mem_rsp_data = $urandom;
        mem_rsp_err = 1'b0;
    endtask

    // Abort a load sitting in WAIT with an asynchronous reset; no result may follow.
    task automatic reset_in_wait(input logic [31:0] addr);
        logic ok;
        wait_ld_ready(ok);
        if (!ok) return;
        ld_valid = 1'b1;
        ld_addr = addr;
        ld_funct3 = 3'b010;
        @(posedge clk);
        #1 ld_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1 mem_req_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_ld_ready", 64'(ld_ready), 64'd1);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_req_valid", 64'(mem_req_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Writeback monitor: every presented result is either held from last cycle or popped and checked.
    initial begin
        logic        held = 1'b0;
        logic [32:0] held_val = '0;
        logic [32:0] exp;
        @(negedge clk iff !rst);
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
                wb_ready = 1'b0;
            end else if (wb_valid) begin
                if (held) begin
                    check("wb_hold_data", 64'(wb_data), 64'(held_val[31:0]));
                    check("wb_hold_fault", 64'(wb_fault), 64'(held_val[32]));
                end
                if (hold_req > 0) begin
                    hold_req--;
                    wb_ready = 1'b0;
                end else begin
                    wb_ready = ($urandom_range(0, 2) != 0);
                end
                if (!held) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL wb_unexpected: got data 0x%0h fault %0d, expected none",
                                 wb_data, wb_fault);
                        exp = {wb_fault, wb_data};
                    end else begin
                        exp = exp_q.pop_front();
                        check("wb_data", 64'(wb_data), 64'(exp[31:0]));
                        check("wb_fault", 64'(wb_fault), 64'(exp[32]));
                    end
                    held_val = exp;
                end
                held = !wb_ready;
            end else begin
                held = 1'b0;
                wb_ready = ($urandom_range(0, 1) != 0);
            end
        end
    end

    initial begin
        logic [2:0] f3;
        int n;
        #1;
        check("reset_ld_ready", 64'(ld_ready), 64'd1);
        check("reset_req_valid", 64'(mem_req_valid), 64'd0);
        check("reset_wb_valid", 64'(wb_valid), 64'd0);
        check("reset_wb_data", 64'(wb_data), 64'd0);
        check("reset_wb_fault", 64'(wb_fault), 64'd0);
        check("rsp_ready_tied", 64'(mem_rsp_ready), 64'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        do_load(32'h8000_0004, 3'b010, 32'hDEAD_BEEF, 1'b0, 0, 0);
        do_load(32'h8000_0003, 3'b000, 32'h8012_3456, 1'b0, 0, 0);
        do_load(32'h8000_0003, 3'b100, 32'h8012_3456, 1'b0, 0, 0);
        do_load(32'h8000_0002, 3'b001, 32'h8012_3456, 1'b0, 0, 0);
        do_load(32'h8000_0002, 3'b101, 32'h8012_3456, 1'b0, 1, 2);
        do_load(32'h8000_0002, 3'b010, 32'h1234_5678, 1'b0, 0, 0);
        do_load(32'h8000_0000, 3'b011, 32'h1234_5678, 1'b0, 0, 0);
        do_load(32'h8000_0001, 3'b001, 32'h1234_5678, 1'b0, 0, 0);
        hold_req = 3;
        do_load(32'h8000_0010, 3'b010, 32'hCAFE_F00D, 1'b1, 5, 1);
        do_load(32'h8000_0020, 3'b010, 32'h0BAD_0BAD, 1'b0, 0, TMO);
        do_load(32'h8000_0024, 3'b010, 32'h1357_9BDF, 1'b0, 0, TMO - 1);
        do_load(32'h8000_0028, 3'b010, 32'h2468_ACE0, 1'b0, 0, TMO + 3);
        do_load(32'h8000_002C, 3'b010, 32'hA5A5_5A5A, 1'b0, 0, 0);
        reset_in_wait(32'h8000_0030);
        do_load(32'h8000_0031, 3'b000, 32'h00C3_7F00, 1'b0, 0, 0);

        for (int i = 0; i < 200; i++) begin
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 5));
            do_load($urandom, f3, $urandom, ($urandom_range(0, 7) == 0),
                    $urandom_range(0, 3), $urandom_range(0, TMO + 1));
        end

        n = 0;
        while ((exp_q.size() != 0 || wb_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
